bus_fifo_burst_ctrl: RTL and testbench

//  Sequences burst reads from the system memory bus into the 128-in/64-out bus FIFO feeding the SHA3 core.

---
 rtl/bus_fifo_ctrl_pkg.sv | 17 +
 rtl/bus_fifo_credit.sv | 29 ++
 rtl/bus_fifo_burst_ctrl.sv | 159 +++++++++++++++
 tb/tb_bus_fifo_burst_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fifo_ctrl_pkg.sv
// Shared types and constants for the bus-to-FIFO burst controller.
package bus_fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    CHECK,
    REQ,
    DATA,
    FINISH
  } state_t;

  // One bus beat is 128 bits: 16 bytes on the bus, two 64-bit FIFO words.
  localparam int BEAT_BYTES     = 16;
  localparam int WORDS_PER_BEAT = 2;

endpackage

// File: rtl/bus_fifo_credit.sv
// Burst sizing and FIFO space check for the burst controller.
// blen is the next burst length in beats; space_ok says the FIFO can take all of it.
module bus_fifo_credit
  import bus_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int MAX_BURST = 8,
  localparam int LW       = $clog2(DEPTH) + 1,
  localparam int BW       = $clog2(MAX_BURST + 1)
) (
  input  logic [15:0]   remaining,
  input  logic [LW-1:0] fifo_level,
  output logic [BW-1:0] blen,
  output logic          space_ok
);

  localparam logic [15:0]   MAXB16  = 16'(MAX_BURST);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [LW-1:0] space;
  logic [LW-1:0] need;

  // remaining is below MAX_BURST in the second branch, so the slice is lossless
  assign blen     = (remaining >= MAXB16) ? MAXB16[BW-1:0] : remaining[BW-1:0];
  assign space    = DEPTH_L - fifo_level;
  assign need     = LW'(int'(blen) * WORDS_PER_BEAT);
  assign space_ok = (space >= need);

endmodule

// File: rtl/bus_fifo_burst_ctrl.sv
// Burst read sequencer feeding the 128-in/64-out SHA3 bus FIFO.
// Splits a transfer into bursts of at most MAX_BURST beats, requests a burst
// only once the FIFO has room for all of it, and gates consumer pops on empty.
// Optional build macro BUS_FIFO_CTRL_STATS_EN adds stat_beats/stat_stall counters.
module bus_fifo_burst_ctrl
  import bus_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int MAX_BURST = 8,
  parameter int AW        = 32,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [15:0]   total_beats,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          m_req,
  output logic [AW-1:0] m_addr,
  output logic [7:0]    m_len,
  input  logic          m_ack,
  input  logic          m_rvalid,
  input  logic [127:0]  m_rdata,
  input  logic          m_rlast,
  output logic          fifo_clr,
  output logic          fifo_wr_en,
  output logic [127:0]  fifo_wr_data,
  input  logic [LW-1:0] fifo_level,
  input  logic          fifo_empty,
  input  logic          cons_rd_req,
  output logic          fifo_rd_en
`ifdef BUS_FIFO_CTRL_STATS_EN
  ,
  output logic [31:0]   stat_beats,
  output logic [31:0]   stat_stall
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);

  state_t        state;
  logic [15:0]   remaining;
  logic [BW-1:0] burst_len;
  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] blen;
  logic          space_ok;
  logic          last_beat;

  bus_fifo_credit #(
    .DEPTH     (DEPTH),
    .MAX_BURST (MAX_BURST)
  ) u_credit (
    .remaining  (remaining),
    .fifo_level (fifo_level),
    .blen       (blen),
    .space_ok   (space_ok)
  );

  assign last_beat    = (beat_cnt == BW'(1));
  assign fifo_wr_en   = (state == DATA) && m_rvalid;
  assign fifo_wr_data = fifo_wr_en ? m_rdata : '0;
  assign fifo_rd_en   = cons_rd_req && !fifo_empty;

  // Transfer sequencer: command accept, FIFO clear, space wait, request, beat count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      m_req     <= 1'b0;
      m_addr    <= '0;
      m_len     <= '0;
      fifo_clr  <= 1'b0;
      remaining <= '0;
      burst_len <= '0;
      beat_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (total_beats == 16'd0) begin
              // empty transfer: no bus traffic and the FIFO is left untouched
              done <= 1'b1;
            end else begin
              busy      <= 1'b1;
              fifo_clr  <= 1'b1;
              remaining <= total_beats;
              m_addr    <= src_addr;
              state     <= CLR;
            end
          end
        end
        CLR: begin
          fifo_clr <= 1'b0;
          state    <= CHECK;
        end
        CHECK: begin
          // consumer pops only add room while waiting, so a pass here stays valid
          if (space_ok) begin
            m_req     <= 1'b1;
            m_len     <= 8'(blen) - 8'd1;
            burst_len <= blen;
            beat_cnt  <= blen;
            state     <= REQ;
          end
        end
        REQ: begin
          if (m_ack) begin
            m_req <= 1'b0;
            state <= DATA;
          end
        end
        DATA: begin
          if (m_rvalid) begin
            beat_cnt <= beat_cnt - BW'(1);
            // the local count ends the burst; m_rlast is only cross-checked
            if (m_rlast != last_beat) err <= 1'b1;
            if (last_beat) begin
              m_addr    <= m_addr + AW'(int'(burst_len) * BEAT_BYTES);
              remaining <= remaining - 16'(burst_len);
              if (remaining == 16'(burst_len)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= FINISH;
              end else begin
                state <= CHECK;
              end
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_FIFO_CTRL_STATS_EN
  // Saturating counters of beats written and cycles stalled waiting for FIFO space
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else if ((state == IDLE) && start) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (fifo_wr_en && (stat_beats != '1)) stat_beats <= stat_beats + 32'd1;
      if ((state == CHECK) && !space_ok && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_fifo_burst_ctrl.sv
// Self-checking bench for bus_fifo_burst_ctrl: bus responder, FIFO level model,
// write-data and burst scoreboards, table-driven transfers plus corner sequences.
module tb_bus_fifo_burst_ctrl;

  localparam int DEPTH     = 32;
  localparam int MAX_BURST = 8;
  localparam int AW        = 32;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [15:0]   total_beats = '0;
  logic          busy, done, err, m_req;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;
  logic          m_ack = 1'b0;
  logic          m_rvalid = 1'b0;
  logic [127:0]  m_rdata = '0;
  logic          m_rlast = 1'b0;
  logic          fifo_clr, fifo_wr_en;
  logic [127:0]  fifo_wr_data;
  logic [LW-1:0] fifo_level;
  logic          fifo_empty;
  logic          cons_rd_req = 1'b0;
  logic          fifo_rd_en;
`ifdef BUS_FIFO_CTRL_STATS_EN
  logic [31:0]   stat_beats, stat_stall;
`endif

  bus_fifo_burst_ctrl #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .total_beats(total_beats), .busy(busy), .done(done), .err(err),
    .m_req(m_req), .m_addr(m_addr), .m_len(m_len), .m_ack(m_ack),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .fifo_clr(fifo_clr), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty),
    .cons_rd_req(cons_rd_req), .fifo_rd_en(fifo_rd_en)
`ifdef BUS_FIFO_CTRL_STATS_EN
    , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO word-count model; freezes while fifo_empty is being overridden
  logic [LW-1:0] level = '0;
  logic          force_en = 1'b0;
  logic          force_empty = 1'b0;
  assign fifo_level = level;
  assign fifo_empty = force_en ? force_empty : (level == '0);

  always @(posedge clk) begin
    if (fifo_clr)      level <= '0;
    else if (!force_en) level <= level + (fifo_wr_en ? LW'(2) : LW'(0)) - (fifo_rd_en ? LW'(1) : LW'(0));
  end

  // Scoreboards
  typedef struct { logic [31:0] a; logic [7:0] l; } burst_t;
  burst_t       bq[$];
  logic [127:0] exp_q[$];
  int           wr_cnt = 0, done_cnt = 0, clr_cnt = 0;
  bit           req_d = 1'b0;
  int           inj_beat = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_d = 1'b0;
    end else begin
      if (fifo_wr_en) begin
        wr_cnt++;
        check("fifo_room", level <= LW'(DEPTH - 2), 1'b1);
        if (exp_q.size() == 0) check("wr_unexpected", 1'b1, 1'b0);
        else check("wr_data", fifo_wr_data, exp_q.pop_front());
      end
      if (m_req && !req_d) begin
        if (bq.size() == 0) check("req_unexpected", 1'b1, 1'b0);
        else begin
          burst_t e;
          e = bq.pop_front();
          check("m_addr", m_addr, e.a);
          check("m_len", m_len, e.l);
        end
      end
      req_d = m_req;
      if (done) done_cnt++;
      if (fifo_clr) clr_cnt++;
    end
  end

  // Bus responder: acks after a random delay, returns m_len+1 beats with random gaps
  initial begin
    int len;
    logic [127:0] d;
    forever begin
      @(posedge clk); #1;
      if (m_req && rst_n) begin
        len = int'(m_len);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        m_ack = 1'b1;
        @(posedge clk); #1;
        m_ack = 1'b0;
        for (int b = 0; b <= len; b++) begin
          if (!rst_n) break;
          if ($urandom_range(0, 3) == 0) begin
            m_rvalid = 1'b0;
            @(posedge clk); #1;
            if (!rst_n) break;
          end
          d = {$urandom, $urandom, $urandom, $urandom};
          exp_q.push_back(d);
          m_rdata  = d;
          m_rvalid = 1'b1;
          m_rlast  = (b == len) || (b == inj_beat);
          @(posedge clk); #1;
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
      end
    end
  end

  task automatic push_bursts(input logic [31:0] addr, input int beats);
    burst_t e;
    int rem, b;
    rem = beats;
    e.a = addr;
    while (rem > 0) begin
      b   = (rem < MAX_BURST) ? rem : MAX_BURST;
      e.l = 8'(b - 1);
      bq.push_back(e);
      e.a = e.a + 32'(16 * b);
      rem = rem - b;
    end
  endtask

  task automatic issue_start(input logic [31:0] addr, input int beats);
    @(posedge clk); #1;
    start = 1'b1; src_addr = addr; total_beats = 16'(beats);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", got, 1'b1);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_m_req", m_req, 1'b0);
    check("rst_fifo_clr", fifo_clr, 1'b0);
    check("rst_fifo_wr_en", fifo_wr_en, 1'b0);
    check("rst_m_addr", m_addr, '0);
    check("rst_m_len", m_len, '0);
    check("rst_fifo_wr_data", fifo_wr_data, '0);
  endtask

  typedef struct { logic [31:0] addr; int beats; bit cons; int inj; bit exp_err; } xfer_t;
  typedef struct { bit cons; bit empty; bit exp; } rd_vec_t;

  task automatic do_xfer(input xfer_t x);
    int w0, d0, c0;
    cons_rd_req = x.cons;
    inj_beat    = x.inj;
    push_bursts(x.addr, x.beats);
    w0 = wr_cnt; d0 = done_cnt; c0 = clr_cnt;
    issue_start(x.addr, x.beats);
    check("busy_on", busy, x.beats != 0);
    check("err_cleared", err, 1'b0);
    if (x.beats == 0) check("done_zero", done, 1'b1);
    else wait_done();
    repeat (3) @(negedge clk);
    #1;
    check("beats_written", wr_cnt - w0, x.beats);
    check("done_pulses", done_cnt - d0, 1);
    check("clr_pulses", clr_cnt - c0, x.beats != 0);
    check("err_end", err, x.exp_err);
    check("busy_off", busy, 1'b0);
    check("bursts_left", bq.size(), 0);
`ifdef BUS_FIFO_CTRL_STATS_EN
    check("stat_beats", stat_beats, x.beats);
`endif
    inj_beat = -1;
  endtask

  initial begin
    xfer_t   xt[7];
    rd_vec_t rv[4];
    int      w0;
    bit      req_seen, full_seen;

    xt[0] = '{32'h0000_1000, 20, 1'b1, -1, 1'b0};
    xt[1] = '{32'h0000_1000, 12, 1'b1, -1, 1'b0};
    xt[2] = '{32'h0000_0000,  0, 1'b1, -1, 1'b0};
    xt[3] = '{32'h0000_4000,  8, 1'b1,  2, 1'b1};
    xt[4] = '{32'h0000_5000,  4, 1'b1, -1, 1'b0};
    xt[5] = '{32'hFFFF_FF80, 12, 1'b1, -1, 1'b0};
    xt[6] = '{32'h0000_0020,  1, 1'b0, -1, 1'b0};

    rv[0] = '{1'b1, 1'b1, 1'b0};
    rv[1] = '{1'b1, 1'b0, 1'b1};
    rv[2] = '{1'b0, 1'b0, 1'b0};
    rv[3] = '{1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;

    // Pop gating with the empty flag overridden
    force_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cons_rd_req = rv[i].cons;
      force_empty = rv[i].empty;
      #1;
      check("fifo_rd_en", fifo_rd_en, rv[i].exp);
    end
    force_en = 1'b0;
    cons_rd_req = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) do_xfer(xt[i]);

    // Space stall: consumer idle until two bursts fill the FIFO
    cons_rd_req = 1'b0;
    push_bursts(32'h0000_3000, 24);
    w0 = wr_cnt;
    issue_start(32'h0000_3000, 24);
    full_seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (level == LW'(DEPTH)) begin full_seen = 1'b1; break; end
    end
    check("level_full", full_seen, 1'b1);
    req_seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #2;
      if (m_req) req_seen = 1'b1;
    end
    check("req_withheld", req_seen, 1'b0);
    check("bursts_pending", bq.size(), 1);
    cons_rd_req = 1'b1;
    wait_done();
    repeat (3) @(negedge clk);
    #1;
    check("stall_beats", wr_cnt - w0, 24);
    check("stall_bursts_left", bq.size(), 0);
`ifdef BUS_FIFO_CTRL_STATS_EN
    check("stat_stall_min", stat_stall >= 32'd10, 1'b1);
`endif

    // Asynchronous reset in the middle of a burst
    cons_rd_req = 1'b1;
    push_bursts(32'h0000_6000, 8);
    w0 = wr_cnt;
    issue_start(32'h0000_6000, 8);
    full_seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (wr_cnt - w0 >= 4) begin full_seen = 1'b1; break; end
    end
    check("mid_burst_reached", full_seen, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();
    bq.delete();
    rst_n = 1'b1;
    do_xfer('{32'h0000_7000, 4, 1'b1, -1, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
